// File: rtl/axi_sram_pkg.sv
// Shared constants, FSM states and helpers for the SRAM-backed AXI4 responder.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RDATA
    } state_t;

    // WRAP and the reserved encoding are served as INCR but flagged SLVERR
    function automatic logic burst_bad(input logic [1:0] burst);
        return !(burst == BURST_FIXED || burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/sram_byte_wr.sv
// Single-port synchronous SRAM, registered read, per-byte write enables.
module sram_byte_wr
    import axi_sram_pkg::*;
#(
    parameter int WORDS = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [DW/8-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DW / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi_sram_resp.sv
// AXI4 memory target on block SRAM; one transaction at a time, per-ID responses.
// Define AXI_SRAM_BYTE_STROBE_EN to honour wstrb; otherwise every beat writes the whole word.
module axi_sram_resp
    import axi_sram_pkg::*;
#(
    parameter int SRAM_BYTES = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRS      = 27,
    parameter int REQID      = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDRS-1:0]        axi_awaddr_i,
    input  logic [REQID-1:0]        axi_awid_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,

    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic                    axi_wlast_i,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,

    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [REQID-1:0]        axi_bid_o,

    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDRS-1:0]        axi_araddr_i,
    input  logic [REQID-1:0]        axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,

    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic                    axi_rlast_o,
    output logic [1:0]              axi_rresp_o,
    output logic [REQID-1:0]        axi_rid_o,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o
);

    localparam int AB = $clog2(SRAM_BYTES);
    localparam int IW = AB - 2;
    localparam int NB = DATA_WIDTH / 8;

    state_t state, state_nx;

    logic             prefer_wr;
    logic [REQID-1:0] id_q;
    logic [7:0]       len_q;
    logic [7:0]       rcnt;
    logic [8:0]       wcnt;
    logic             step_q;
    logic             err_q;
    logic [IW-1:0]    addr_q;
    logic [1:0]       bresp_q;

    logic            idle;
    logic            aw_go;
    logic            ar_go;
    logic            w_go;
    logic            w_in;
    logic            r_go;
    logic            r_last;
    logic            sram_en;
    logic            sram_we;
    logic [IW-1:0]   sram_addr;
    logic [NB-1:0]   be;
    logic [DATA_WIDTH-1:0] sram_q;
    logic            unused_bits;

    assign idle   = (state == S_IDLE);
    assign aw_go  = axi_awvalid_i & axi_awready_o;
    assign ar_go  = axi_arvalid_i & axi_arready_o;
    assign w_go   = (state == S_WDATA) & axi_wvalid_i;
    assign w_in   = (wcnt <= {1'b0, len_q});
    assign r_go   = (state == S_RDATA) & axi_rready_i;
    assign r_last = (rcnt == len_q);

    assign axi_awready_o = idle & (!axi_arvalid_i | prefer_wr);
    assign axi_arready_o = idle & (!axi_awvalid_i | !prefer_wr);
    assign axi_wready_o  = (state == S_WDATA);
    assign axi_bvalid_o  = (state == S_WRESP);
    assign axi_rvalid_o  = (state == S_RDATA);

    assign axi_bresp_o = axi_bvalid_o ? bresp_q : RESP_OKAY;
    assign axi_bid_o   = axi_bvalid_o ? id_q : '0;
    assign axi_rlast_o = axi_rvalid_o & r_last;
    assign axi_rresp_o = (axi_rvalid_o & err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid_o   = axi_rvalid_o ? id_q : '0;
    assign axi_rdata_o = axi_rvalid_o ? sram_q : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RESET;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RESET: state_nx = S_IDLE;
            S_IDLE: begin
                if (aw_go) begin
                    state_nx = S_WDATA;
                end else if (ar_go) begin
                    state_nx = S_RDATA;
                end
            end
            S_WDATA: if (w_go && axi_wlast_i) state_nx = S_WRESP;
            S_WRESP: if (axi_bready_i) state_nx = S_IDLE;
            S_RDATA: if (r_go && r_last) state_nx = S_IDLE;
            default: state_nx = S_RESET;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_wr <= 1'b1;
            id_q      <= '0;
            len_q     <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_go) begin
                prefer_wr <= 1'b0;
                id_q      <= axi_awid_i;
                len_q     <= axi_awlen_i;
                step_q    <= (axi_awburst_i != BURST_FIXED);
                err_q     <= burst_bad(axi_awburst_i);
                addr_q    <= axi_awaddr_i[AB-1:2];
                wcnt      <= '0;
            end else if (ar_go) begin
                prefer_wr <= 1'b1;
                id_q      <= axi_arid_i;
                len_q     <= axi_arlen_i;
                step_q    <= (axi_arburst_i != BURST_FIXED);
                err_q     <= burst_bad(axi_arburst_i);
                // first beat is read now, so point at the second one
                addr_q    <= axi_araddr_i[AB-1:2]
                           + IW'(axi_arburst_i != BURST_FIXED);
                rcnt      <= '0;
            end else if (w_go) begin
                if (w_in) begin
                    wcnt   <= wcnt + 9'd1;
                    addr_q <= addr_q + IW'(step_q);
                end
                if (axi_wlast_i) begin
                    bresp_q <= (err_q || wcnt != {1'b0, len_q})
                             ? RESP_SLVERR : RESP_OKAY;
                end
            end else if (r_go && !r_last) begin
                rcnt   <= rcnt + 8'd1;
                addr_q <= addr_q + IW'(step_q);
            end
        end
    end

    // beats past awlen are acknowledged but never reach the array
    assign sram_en   = ar_go | (w_go & w_in) | (r_go & !r_last);
    assign sram_we   = (state == S_WDATA);
    assign sram_addr = ar_go ? axi_araddr_i[AB-1:2] : addr_q;

`ifdef AXI_SRAM_BYTE_STROBE_EN
    assign be = axi_wstrb_i;
    assign unused_bits = ^{axi_awaddr_i[ADDRS-1:AB], axi_awaddr_i[1:0],
                           axi_araddr_i[ADDRS-1:AB], axi_araddr_i[1:0]};
`else
    assign be = '1;
    assign unused_bits = ^{axi_awaddr_i[ADDRS-1:AB], axi_awaddr_i[1:0],
                           axi_araddr_i[ADDRS-1:AB], axi_araddr_i[1:0],
                           axi_wstrb_i};
`endif

    sram_byte_wr #(
        .WORDS (SRAM_BYTES / 4),
        .AW    (IW),
        .DW    (DATA_WIDTH)
    ) u_sram (
        .clock (clock),
        .en    (sram_en),
        .we    (sram_we),
        .be    (be),
        .addr  (sram_addr),
        .wdata (axi_wdata_i),
        .rdata (sram_q)
    );

endmodule

// File: tb/tb_axi_sram_resp.sv
// Directed plus randomized bench for axi_sram_resp against a word-array model.
module tb_axi_sram_resp;
    import axi_sram_pkg::*;

    localparam int WORDS = 512;
`ifdef AXI_SRAM_BYTE_STROBE_EN
    localparam logic [31:0] EXP_STRB = 32'h00BB00DD;
`else
    localparam logic [31:0] EXP_STRB = 32'hAABBCCDD;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        awvalid, awready;
    logic [26:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [26:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic [31:0] rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [WORDS];
    logic [31:0] wbuf [16];

    always #5 clock = ~clock;

    axi_sram_resp dut (
        .clock         (clock),
        .reset         (reset),
        .axi_awvalid_i (awvalid),
        .axi_awready_o (awready),
        .axi_awaddr_i  (awaddr),
        .axi_awid_i    (awid),
        .axi_awlen_i   (awlen),
        .axi_awburst_i (awburst),
        .axi_wvalid_i  (wvalid),
        .axi_wready_o  (wready),
        .axi_wlast_i   (wlast),
        .axi_wstrb_i   (wstrb),
        .axi_wdata_i   (wdata),
        .axi_bvalid_o  (bvalid),
        .axi_bready_i  (bready),
        .axi_bresp_o   (bresp),
        .axi_bid_o     (bid),
        .axi_arvalid_i (arvalid),
        .axi_arready_o (arready),
        .axi_araddr_i  (araddr),
        .axi_arid_i    (arid),
        .axi_arlen_i   (arlen),
        .axi_arburst_i (arburst),
        .axi_rvalid_o  (rvalid),
        .axi_rready_i  (rready),
        .axi_rlast_o   (rlast),
        .axi_rresp_o   (rresp),
        .axi_rid_o     (rid),
        .axi_rdata_o   (rdata)
    );

    function automatic void chk(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    task automatic axi_write(input logic [26:0] addr, input logic [3:0] id,
                             input int len, input logic [1:0] burst,
                             input int nb, input logic [3:0] strb,
                             output logic [1:0] br);
        int w;
        int t;
        logic [31:0] m;
        logic [1:0] er;
        awvalid = 1'b1; awaddr = addr; awid = id;
        awlen = len[7:0]; awburst = burst;
        #1;
        t = 0;
        while (!awready && t < 50) begin
            @(posedge clock); #1; t++;
        end
        chk("aw_wait", {63'd0, t < 50}, 64'd1);
        @(posedge clock); #1;
        awvalid = 1'b0;
        w = int'(addr >> 2) % WORDS;
        for (int b = 0; b < nb; b++) begin
            wvalid = 1'b1; wdata = wbuf[b % 16];
            wstrb = strb; wlast = (b == nb - 1);
            chk("wready", {63'd0, wready}, 64'd1);
            @(posedge clock); #1;
            if (b <= len) begin
`ifdef AXI_SRAM_BYTE_STROBE_EN
                m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
`else
                m = '1;
`endif
                model[w] = (model[w] & ~m) | (wbuf[b % 16] & m);
                if (burst != BURST_FIXED) w = (w + 1) % WORDS;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        er = (nb - 1 != len || burst > BURST_INCR) ? RESP_SLVERR : RESP_OKAY;
        chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
        chk("bresp", {62'd0, bresp}, {62'd0, er});
        chk("bid", {60'd0, bid}, {60'd0, id});
        br = bresp;
        bready = 1'b1;
        @(posedge clock); #1;
        bready = 1'b0;
        chk("bvalid_drop", {63'd0, bvalid}, 64'd0);
    endtask

    // mode 0: rready high, 1: toggles every cycle, 2: random
    task automatic axi_read(input logic [26:0] addr, input logic [3:0] id,
                            input int len, input logic [1:0] burst,
                            input int mode, output int cyc,
                            output logic [31:0] lastd, output logic [1:0] lastr);
        int w;
        int b;
        int t;
        logic [1:0] er;
        arvalid = 1'b1; araddr = addr; arid = id;
        arlen = len[7:0]; arburst = burst; rready = 1'b0;
        #1;
        t = 0;
        while (!arready && t < 50) begin
            @(posedge clock); #1; t++;
        end
        chk("ar_wait", {63'd0, t < 50}, 64'd1);
        @(posedge clock); #1;
        arvalid = 1'b0;
        er = (burst > BURST_INCR) ? RESP_SLVERR : RESP_OKAY;
        w = int'(addr >> 2) % WORDS;
        b = 0; cyc = 0; lastd = '0; lastr = '0;
        while (b <= len && cyc < 2000) begin
            if (mode == 0) rready = 1'b1;
            else if (mode == 1) rready = cyc[0];
            else rready = 1'($urandom_range(0, 1));
            chk("rvalid", {63'd0, rvalid}, 64'd1);
            chk("rdata", {32'd0, rdata}, {32'd0, model[w]});
            if (rready) begin
                chk("rlast", {63'd0, rlast}, {63'd0, b == len});
                chk("rid", {60'd0, rid}, {60'd0, id});
                chk("rresp", {62'd0, rresp}, {62'd0, er});
                lastd = rdata; lastr = rresp;
                b++;
                if (burst != BURST_FIXED) w = (w + 1) % WORDS;
            end
            @(posedge clock); #1;
            cyc++;
        end
        rready = 1'b0;
        chk("r_beats", 64'(b), 64'(len + 1));
        chk("r_idle", {63'd0, rvalid}, 64'd0);
    endtask

    initial begin
        int cyc;
        int len;
        logic [31:0] d;
        logic [1:0] r;
        logic [26:0] a;
        logic [1:0] bt;
        logic [3:0] sb;

        reset = 1'b1;
        awvalid = 1'b1; awaddr = '0; awid = '0; awlen = '0; awburst = '0;
        wvalid = 1'b0; wlast = 1'b0; wstrb = '0; wdata = '0; bready = 1'b0;
        arvalid = 1'b1; araddr = '0; arid = '0; arlen = '0; arburst = '0;
        rready = 1'b1;
        for (int i = 0; i < WORDS; i++) model[i] = '0;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outs",
            {14'd0, awready, wready, bvalid, bresp, bid, arready, rvalid,
             rlast, rresp, rid, rdata}, 64'd0);
        awvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        // simultaneous AW/AR straight out of reset
        awvalid = 1'b1; awaddr = 27'h300; awid = 4'd3; awburst = BURST_INCR;
        arvalid = 1'b1; araddr = 27'h300; arid = 4'd5; arburst = BURST_INCR;
        #1;
        chk("arb_first", {62'd0, awready, arready}, 64'b10);
        arvalid = 1'b0;
        wbuf[0] = $urandom;
        axi_write(27'h300, 4'd3, 0, BURST_INCR, 1, 4'hF, r);
        awvalid = 1'b1; awaddr = 27'h304; arvalid = 1'b1;
        #1;
        chk("arb_second", {62'd0, awready, arready}, 64'b01);
        awvalid = 1'b0;
        axi_read(27'h300, 4'd5, 0, BURST_INCR, 0, cyc, d, r);
        chk("arb_rd_data", {32'd0, d}, {32'd0, wbuf[0]});

        // clear the whole array so every later read has a defined model value
        wbuf[0] = '0;
        axi_write(27'h0, 4'd0, 255, BURST_INCR, 256, 4'hF, r);
        axi_write(27'h400, 4'd0, 255, BURST_INCR, 256, 4'hF, r);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11111111 * (i + 1);
        axi_write(27'h100, 4'd1, 3, BURST_INCR, 4, 4'hF, r);
        chk("incr_bresp", {62'd0, r}, {62'd0, RESP_OKAY});
        axi_read(27'h100, 4'd2, 3, BURST_INCR, 0, cyc, d, r);
        chk("b2b_cycles", 64'(cyc), 64'd4);
        chk("incr_last", {32'd0, d}, 64'h44444444);

        wbuf[0] = 32'hAABBCCDD;
        axi_write(27'h40, 4'd7, 0, BURST_INCR, 1, 4'h5, r);
        axi_read(27'h40, 4'd7, 0, BURST_INCR, 0, cyc, d, r);
        chk("strobe", {32'd0, d}, {32'd0, EXP_STRB});

        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        axi_write(27'h200, 4'd8, 7, BURST_INCR, 8, 4'hF, r);
        axi_read(27'h200, 4'd8, 7, BURST_INCR, 1, cyc, d, r);
        chk("stall_last", {32'd0, d}, {32'd0, wbuf[7]});

        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        axi_write(27'h280, 4'd9, 3, BURST_INCR, 3, 4'hF, r);
        chk("short_wlast", {62'd0, r}, {62'd0, RESP_SLVERR});
        axi_write(27'h2C0, 4'd10, 3, BURST_INCR, 6, 4'hF, r);
        chk("long_wlast", {62'd0, r}, {62'd0, RESP_SLVERR});
        axi_read(27'h2C0, 4'd10, 5, BURST_INCR, 0, cyc, d, r);
        chk("extra_discard", {32'd0, d}, 64'd0);
        axi_write(27'h180, 4'd11, 1, BURST_WRAP, 2, 4'hF, r);
        chk("wrap_wr_resp", {62'd0, r}, {62'd0, RESP_SLVERR});
        axi_read(27'h100, 4'd4, 3, BURST_WRAP, 0, cyc, d, r);
        chk("wrap_rd_resp", {62'd0, r}, {62'd0, RESP_SLVERR});

        axi_write(27'h380, 4'd12, 2, BURST_FIXED, 3, 4'hF, r);
        axi_read(27'h380, 4'd12, 2, BURST_FIXED, 0, cyc, d, r);
        chk("fixed_hold", {32'd0, d}, {32'd0, wbuf[2]});

        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        axi_write(27'd2044, 4'd13, 1, BURST_INCR, 2, 4'hF, r);
        axi_read(27'h0, 4'd13, 0, BURST_INCR, 0, cyc, d, r);
        chk("top_wrap", {32'd0, d}, {32'd0, wbuf[1]});
        axi_read(27'h800, 4'd14, 0, BURST_INCR, 0, cyc, d, r);
        chk("alias", {32'd0, d}, {32'd0, wbuf[1]});

        // reset in the middle of a read burst
        arvalid = 1'b1; araddr = 27'h100; arid = 4'd6;
        arlen = 8'd7; arburst = BURST_INCR; rready = 1'b1;
        #1;
        cyc = 0;
        while (!arready && cyc < 50) begin
            @(posedge clock); #1; cyc++;
        end
        @(posedge clock); #1;
        arvalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_outs",
            {14'd0, awready, wready, bvalid, bresp, bid, arready, rvalid,
             rlast, rresp, rid, rdata}, 64'd0);
        rready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        axi_read(27'h100, 4'd15, 3, BURST_INCR, 0, cyc, d, r);
        chk("post_reset", {32'd0, d}, 64'h44444444);

        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(0, 7);
            a = 27'($urandom) & ~27'd3;
            bt = ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR;
            sb = 4'($urandom);
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            axi_write(a, 4'($urandom), len, bt, len + 1, sb, r);
            axi_read(a, 4'($urandom), len, bt, 2, cyc, d, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
